// File: rtl/mem_pkg.sv
// Shared funct3 encodings, byte-enable constants and FSM states for the
// handshaked memory stage.
package mem_pkg;

    localparam logic [2:0] LdB  = 3'b000;
    localparam logic [2:0] LdH  = 3'b001;
    localparam logic [2:0] LdW  = 3'b010;
    localparam logic [2:0] LdBu = 3'b100;
    localparam logic [2:0] LdHu = 3'b101;

    localparam logic [2:0] StB  = 3'b000;
    localparam logic [2:0] StH  = 3'b001;
    localparam logic [2:0] StW  = 3'b010;

    localparam logic [3:0] BeByte = 4'b0001;
    localparam logic [3:0] BeHalf = 4'b0011;
    localparam logic [3:0] BeWord = 4'b1111;

    typedef enum logic {IDLE, WAIT} memState_t;

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_stage_hs_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication/enables, load extraction and
// sign/zero extension, and misalignment detection for the selected access size.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        isStore,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_ext,
    output logic        misalign
);

    logic [31:0] rShift;
    logic [7:0]  rByte;
    logic [15:0] rHalf;

    assign rShift = rdata >> {off, 3'b000};
    assign rByte  = rShift[7:0];
    assign rHalf  = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata    = wd;
        be       = BeWord;
        load_ext = rdata;
        misalign = 1'b0;
        if (isStore) begin
            case (store_type)
                StB: begin
                    wdata = {4{wd[7:0]}};
                    be    = BeByte << off;
                end
                StH: begin
                    wdata    = {2{wd[15:0]}};
                    be       = BeHalf << off;
                    misalign = off[0];
                end
                StW:     misalign = |off;
                default: ;
            endcase
        end else begin
            case (load_type)
                LdB:  load_ext = {{24{rByte[7]}}, rByte};
                LdBu: load_ext = {24'b0, rByte};
                LdH: begin
                    load_ext = {{16{rHalf[15]}}, rHalf};
                    misalign = off[0];
                end
                LdHu: begin
                    load_ext = {16'b0, rHalf};
                    misalign = off[0];
                end
                LdW:     misalign = |off;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_hs.sv
// RV32IM memory stage driving a variable-latency req/ack data memory, stalling
// upstream while busy and registering results into the MEM/WB pipeline register.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_m,
    input  logic                reg_write_m,
    input  logic                mem_read_m,
    input  logic                mem_write_m,
    input  logic [1:0]          result_src_m,
    input  logic [RA_W-1:0]     rd_m,
    input  logic [XLEN-1:0]     pc_plus4_m,
    input  logic [XLEN-1:0]     alu_result_m,
    input  logic [XLEN-1:0]     write_data_m,
    input  logic [2:0]          load_type_m,
    input  logic [2:0]          store_type_m,
    output logic                stall_m,
    mem_stage_hs_if.master      dmem,
    output logic                valid_w,
    output logic                reg_write_w,
    output logic [1:0]          result_src_w,
    output logic [RA_W-1:0]     rd_w,
    output logic [XLEN-1:0]     pc_plus4_w,
    output logic [XLEN-1:0]     alu_result_w,
    output logic [XLEN-1:0]     read_data_w,
    output logic                misalign_w,
    output logic                fault_w
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    if (XLEN != 32) begin : gXlenCheck
        $error("mem_stage_hs: XLEN must be 32");
    end
    if (TIMEOUT < 1) begin : gTimeoutCheck
        $error("mem_stage_hs: TIMEOUT must be at least 1");
    end

    memState_t     state;
    logic [CntW-1:0] cnt;
    logic          memOp, laneMisalign, misaligned, accessOp;
    logic          complete, timeoutHit;
    logic [31:0]   alignWdata, loadExt;
    logic [3:0]    alignBe;

    mem_lane_align uAlign (
        .isStore    (mem_write_m),
        .off        (alu_result_m[1:0]),
        .load_type  (load_type_m),
        .store_type (store_type_m),
        .wd         (write_data_m),
        .rdata      (dmem.rdata),
        .wdata      (alignWdata),
        .be         (alignBe),
        .load_ext   (loadExt),
        .misalign   (laneMisalign)
    );

    assign memOp      = valid_m & (mem_read_m | mem_write_m);
    assign misaligned = memOp & laneMisalign;
    assign accessOp   = memOp & ~laneMisalign;

    assign dmem.req   = ~rst & (((state == IDLE) & accessOp) | (state == WAIT));
    assign dmem.we    = accessOp & mem_write_m;
    assign dmem.addr  = {alu_result_m[XLEN-1:2], 2'b00};
    assign dmem.wdata = alignWdata;
    assign dmem.be    = alignBe;

    assign complete   = dmem.req & dmem.ack;
    assign timeoutHit = (state == WAIT) & (cnt == CntW'(TIMEOUT)) & ~dmem.ack;
    // The abort cycle releases the stall so the faulting instruction retires.
    assign stall_m    = dmem.req & ~dmem.ack & ~timeoutHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accessOp && !dmem.ack) begin
                        state <= WAIT;
                        cnt   <= CntW'(1);
                    end
                end
                WAIT: begin
                    if (dmem.ack || cnt == CntW'(TIMEOUT)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stall_m || !valid_m) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
            rd_w         <= '0;
            pc_plus4_w   <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            misalign_w   <= 1'b0;
            fault_w      <= 1'b0;
        end else begin
            valid_w      <= 1'b1;
            reg_write_w  <= reg_write_m & ~misaligned & ~timeoutHit;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
            pc_plus4_w   <= pc_plus4_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= (complete && mem_read_m) ? loadExt : '0;
            misalign_w   <= misaligned;
            fault_w      <= timeoutHit;
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed scenarios plus randomized
// accesses checked against a byte-arithmetic reference model.
module tb_mem_stage_hs;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            valid_m, reg_write_m, mem_read_m, mem_write_m;
    logic [1:0]      result_src_m;
    logic [RA_W-1:0] rd_m;
    logic [31:0]     pc_plus4_m, alu_result_m, write_data_m;
    logic [2:0]      load_type_m, store_type_m;
    logic            stall_m;
    logic            valid_w, reg_write_w, misalign_w, fault_w;
    logic [1:0]      result_src_w;
    logic [RA_W-1:0] rd_w;
    logic [31:0]     pc_plus4_w, alu_result_w, read_data_w;

    int checks = 0;
    int errors = 0;

    mem_stage_hs_if #(.XLEN(XLEN)) dmem ();

    mem_stage_hs #(.XLEN(XLEN), .RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .result_src_m (result_src_m),
        .rd_m         (rd_m),
        .pc_plus4_m   (pc_plus4_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .load_type_m  (load_type_m),
        .store_type_m (store_type_m),
        .stall_m      (stall_m),
        .dmem         (dmem.master),
        .valid_w      (valid_w),
        .reg_write_w  (reg_write_w),
        .result_src_w (result_src_w),
        .rd_w         (rd_w),
        .pc_plus4_w   (pc_plus4_w),
        .alu_result_w (alu_result_w),
        .read_data_w  (read_data_w),
        .misalign_w   (misalign_w),
        .fault_w      (fault_w)
    );

    // Reference model: access size in bytes from funct3[1:0], plain arithmetic on bytes.
    function automatic bit exp_misal(logic [2:0] t, logic [31:0] a);
        int unsigned nb;
        nb = 32'd1 << t[1:0];
        return (a % nb) != 0;
    endfunction

    function automatic logic [31:0] exp_load(logic [2:0] t, logic [31:0] a, logic [31:0] rd);
        int unsigned nb, off;
        logic [63:0] v;
        nb  = 32'd1 << t[1:0];
        off = {30'b0, a[1:0]};
        v   = (64'(rd) >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
        if (t[2] == 1'b0 && nb < 4 && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(bit isStore, logic [2:0] t, logic [31:0] a);
        int unsigned nb, off;
        if (!isStore) return 4'hF;
        nb  = 32'd1 << t[1:0];
        off = {30'b0, a[1:0]};
        return 4'(((32'd1 << nb) - 32'd1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(logic [2:0] t, logic [31:0] wd);
        if (t[1:0] == 2'd0) return {24'b0, wd[7:0]} * 32'h0101_0101;
        if (t[1:0] == 2'd1) return {16'b0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic idle_inputs();
        valid_m = 1'b0; reg_write_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        result_src_m = 2'd0; rd_m = '0; pc_plus4_m = '0; alu_result_m = '0;
        write_data_m = '0; load_type_m = 3'd0; store_type_m = 3'd0;
        dmem.ack = 1'b0; dmem.rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; idle_inputs();
        valid_m = 1'b1; mem_read_m = 1'b1; load_type_m = 3'b010; alu_result_m = 32'h40;
        repeat (2) begin
            #1;
            checks++;
            if ({dmem.req, stall_m} !== 2'b00) begin
                errors++; $display("FAIL reset_req_stall: got %b want 00", {dmem.req, stall_m});
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        checks++;
        if ({valid_w, reg_write_w, misalign_w, fault_w, result_src_w, rd_w} !== '0 ||
            {pc_plus4_w, alu_result_w, read_data_w} !== '0) begin
            errors++; $display("FAIL reset_w: got v=%b rw=%b rd=%0d alu=%h rdat=%h want all 0",
                               valid_w, reg_write_w, rd_w, alu_result_w, read_data_w);
        end
        rst = 1'b0; idle_inputs();
    endtask

    task automatic test_alu();
        @(negedge clk); idle_inputs();
        valid_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd5; alu_result_m = 32'h2A;
        pc_plus4_m = 32'h104;
        #1;
        checks++;
        if ({dmem.req, stall_m} !== 2'b00) begin
            errors++; $display("FAIL alu_req_stall: got %b want 00", {dmem.req, stall_m});
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_w, reg_write_w, rd_w, alu_result_w, pc_plus4_w, read_data_w} !==
            {1'b1, 1'b1, 5'd5, 32'h2A, 32'h104, 32'h0}) begin
            errors++; $display("FAIL alu_w: got v=%b rw=%b rd=%0d alu=%h pc=%h rdat=%h want 1 1 5 2a 104 0",
                               valid_w, reg_write_w, rd_w, alu_result_w, pc_plus4_w, read_data_w);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] want;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); idle_inputs();
            valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd9;
            load_type_m = (s == 0) ? 3'b000 : 3'b100; alu_result_m = 32'h103;
            dmem.ack = 1'b1; dmem.rdata = 32'h80FF_1234;
            want = (s == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            #1;
            checks++;
            if ({dmem.req, dmem.we, dmem.be, stall_m, dmem.addr} !== {1'b1, 1'b0, 4'hF, 1'b0, 32'h100}) begin
                errors++; $display("FAIL lb_req: got req=%b we=%b be=%b stall=%b addr=%h want 1 0 1111 0 100",
                                   dmem.req, dmem.we, dmem.be, stall_m, dmem.addr);
            end
            @(posedge clk); #1;
            checks++;
            if (read_data_w !== want || valid_w !== 1'b1 || reg_write_w !== 1'b1) begin
                errors++; $display("FAIL lb_ext%0d: got %h v=%b rw=%b want %h 1 1",
                                   s, read_data_w, valid_w, reg_write_w, want);
            end
        end
    endtask

    task automatic test_store_align();
        @(negedge clk); idle_inputs();
        valid_m = 1'b1; mem_write_m = 1'b1; store_type_m = 3'b001;
        alu_result_m = 32'h202; write_data_m = 32'h0000_BEEF; dmem.ack = 1'b1;
        #1;
        checks++;
        if ({dmem.req, dmem.we, dmem.be, dmem.wdata, dmem.addr} !==
            {1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h200}) begin
            errors++; $display("FAIL sh_bus: got req=%b we=%b be=%b wdata=%h addr=%h want 1 1 1100 beefbeef 200",
                               dmem.req, dmem.we, dmem.be, dmem.wdata, dmem.addr);
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_w, reg_write_w, misalign_w, fault_w} !== 4'b1000) begin
            errors++; $display("FAIL sh_w: got %b want 1000", {valid_w, reg_write_w, misalign_w, fault_w});
        end
    endtask

    task automatic test_wait_load();
        @(negedge clk); idle_inputs();
        valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd12;
        load_type_m = 3'b010; alu_result_m = 32'h300;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            dmem.ack   = (k == 3);
            dmem.rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h1111_2222;
            #1;
            checks++;
            if (stall_m !== (k < 3) || dmem.req !== 1'b1) begin
                errors++; $display("FAIL wait_stall%0d: got stall=%b req=%b want %b 1",
                                   k, stall_m, dmem.req, (k < 3));
            end
            @(posedge clk); #1;
            checks++;
            if (k < 3 && valid_w !== 1'b0) begin
                errors++; $display("FAIL wait_bubble%0d: got valid_w=%b want 0", k, valid_w);
            end else if (k == 3 && {valid_w, reg_write_w, rd_w, read_data_w} !==
                         {1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF}) begin
                errors++; $display("FAIL wait_done: got v=%b rw=%b rd=%0d rdat=%h want 1 1 12 deadbeef",
                                   valid_w, reg_write_w, rd_w, read_data_w);
            end
        end
    endtask

    task automatic test_misalign();
        @(negedge clk); idle_inputs();
        valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd3;
        load_type_m = 3'b010; alu_result_m = 32'h1002; dmem.ack = 1'b1;
        #1;
        checks++;
        if ({dmem.req, stall_m} !== 2'b00) begin
            errors++; $display("FAIL mis_req: got %b want 00", {dmem.req, stall_m});
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_w, reg_write_w, misalign_w, fault_w} !== 4'b1010) begin
            errors++; $display("FAIL mis_w: got %b want 1010", {valid_w, reg_write_w, misalign_w, fault_w});
        end
    endtask

    task automatic test_timeout();
        int stallCycles;
        bit done;
        @(negedge clk); idle_inputs();
        valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd7;
        load_type_m = 3'b010; alu_result_m = 32'h400;
        stallCycles = 0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (stall_m === 1'b1) begin
                stallCycles++;
                @(posedge clk); #1;
                checks++;
                if (valid_w !== 1'b0) begin
                    errors++; $display("FAIL to_bubble%0d: got valid_w=%b want 0", k, valid_w);
                end
            end else begin
                done = 1'b1;
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!done || stallCycles != int'(TIMEOUT)) begin
            errors++; $display("FAIL to_stall_len: got %0d cycles (released=%b) want %0d",
                               stallCycles, done, TIMEOUT);
        end
        checks++;
        if ({valid_w, reg_write_w, misalign_w, fault_w} !== 4'b1001) begin
            errors++; $display("FAIL to_fault: got %b want 1001", {valid_w, reg_write_w, misalign_w, fault_w});
        end
        @(negedge clk); idle_inputs();
        dmem.ack = 1'b1; dmem.rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({dmem.req, stall_m} !== 2'b00) begin
            errors++; $display("FAIL to_late_req: got %b want 00", {dmem.req, stall_m});
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_w, fault_w, read_data_w} !== '0) begin
            errors++; $display("FAIL to_late_w: got v=%b f=%b rdat=%h want 0", valid_w, fault_w, read_data_w);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk); idle_inputs();
        valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'd20;
        load_type_m = 3'b010; alu_result_m = 32'h500;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({dmem.req, stall_m} !== 2'b00) begin
            errors++; $display("FAIL rw_req_in_rst: got %b want 00", {dmem.req, stall_m});
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_w, reg_write_w, misalign_w, fault_w, rd_w, read_data_w} !== '0) begin
            errors++; $display("FAIL rw_w_rst: got v=%b rw=%b rd=%0d rdat=%h want 0",
                               valid_w, reg_write_w, rd_w, read_data_w);
        end
        @(negedge clk);
        rst = 1'b0; idle_inputs();
        dmem.ack = 1'b1; dmem.rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({dmem.req, stall_m} !== 2'b00) begin
            errors++; $display("FAIL rw_idle_req: got %b want 00", {dmem.req, stall_m});
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_w, reg_write_w, read_data_w} !== '0) begin
            errors++; $display("FAIL rw_late_ack: got v=%b rw=%b rdat=%h want 0", valid_w, reg_write_w, read_data_w);
        end
    endtask

    task automatic test_random();
        logic [2:0]  ldTypes [5];
        logic [2:0]  t;
        logic [31:0] a, wd, rdat, wantRd;
        int          kind, lat;
        bit          rw, mis;
        ldTypes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int it = 0; it < 80; it++) begin
            @(negedge clk); idle_inputs();
            kind = $urandom_range(0, 3);
            lat  = $urandom_range(0, 3);
            a = $urandom; wd = $urandom; rdat = $urandom; rw = 1'($urandom_range(0, 1));
            t = 3'b010;
            valid_m = (kind != 0); reg_write_m = rw; rd_m = 5'($urandom);
            result_src_m = 2'($urandom); pc_plus4_m = $urandom;
            alu_result_m = a; write_data_m = wd;
            if (kind == 2) begin
                t = ldTypes[$urandom_range(0, 4)]; mem_read_m = 1'b1; load_type_m = t;
            end else if (kind == 3) begin
                t = 3'($urandom_range(0, 2)); mem_write_m = 1'b1; store_type_m = t;
            end
            mis = (kind >= 2) && exp_misal(t, a);
            if (kind < 2 || mis) begin
                #1;
                checks++;
                if ({dmem.req, stall_m} !== 2'b00) begin
                    errors++; $display("FAIL rnd%0d_noreq: got %b want 00", it, {dmem.req, stall_m});
                end
                @(posedge clk); #1;
                checks++;
                if ({valid_w, reg_write_w, misalign_w, fault_w} !==
                    {kind != 0, kind == 1 && rw, mis, 1'b0}) begin
                    errors++; $display("FAIL rnd%0d_flags: kind=%0d got %b want %b", it, kind,
                                       {valid_w, reg_write_w, misalign_w, fault_w},
                                       {kind != 0, kind == 1 && rw, mis, 1'b0});
                end
                if (kind == 1) begin
                    checks++;
                    if ({rd_w, alu_result_w, read_data_w} !== {rd_m, a, 32'h0}) begin
                        errors++; $display("FAIL rnd%0d_alu: got rd=%0d alu=%h rdat=%h want %0d %h 0",
                                           it, rd_w, alu_result_w, read_data_w, rd_m, a);
                    end
                end
            end else begin
                wantRd = (kind == 2) ? exp_load(t, a, rdat) : 32'h0;
                for (int k = 0; k <= lat; k++) begin
                    if (k > 0) @(negedge clk);
                    dmem.ack   = (k == lat);
                    dmem.rdata = (k == lat) ? rdat : $urandom;
                    #1;
                    checks++;
                    if ({dmem.req, dmem.we, stall_m, dmem.be, dmem.addr} !==
                        {1'b1, kind == 3, k != lat, exp_be(kind == 3, t, a), a & 32'hFFFF_FFFC} ||
                        (kind == 3 && dmem.wdata !== exp_wdata(t, wd))) begin
                        errors++; $display("FAIL rnd%0d_bus%0d: t=%0d a=%h got req=%b we=%b st=%b be=%b wd=%h want be=%b wd=%h",
                                           it, k, t, a, dmem.req, dmem.we, stall_m, dmem.be, dmem.wdata,
                                           exp_be(kind == 3, t, a), exp_wdata(t, wd));
                    end
                    @(posedge clk); #1;
                    checks++;
                    if (k < lat && valid_w !== 1'b0) begin
                        errors++; $display("FAIL rnd%0d_bubble%0d: got valid_w=%b want 0", it, k, valid_w);
                    end else if (k == lat && {valid_w, reg_write_w, misalign_w, fault_w, rd_w, read_data_w} !==
                                 {1'b1, rw, 1'b0, 1'b0, rd_m, wantRd}) begin
                        errors++; $display("FAIL rnd%0d_done: t=%0d a=%h got v=%b rw=%b rd=%0d rdat=%h want 1 %b %0d %h",
                                           it, t, a, valid_w, reg_write_w, rd_w, read_data_w, rw, rd_m, wantRd);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_load_ext();
        test_store_align();
        test_wait_load();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Pipelined RV32IM memory stage, successor to the single-cycle memory stage.
- Drives an external data memory over a req/ack handshake with variable latency, and stalls the pipeline while the memory is busy.
- Performs store byte-lane alignment and load sign/zero extension, detects misaligned accesses, and aborts accesses that time out.
- Registers results into the MEM/WB pipeline register for the writeback cycle.

Parameters:
- XLEN, 32, datapath width. Only 32 is legal; elaboration fails otherwise.
- RA_W, 5, register-address width.
- TIMEOUT, 15, maximum cycles spent in WAIT before the access is aborted. Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_m  in  1  M-stage instruction valid
- reg_write_m, mem_read_m, mem_write_m  in  1 each  control from EX/MEM
- result_src_m  in  2  writeback select, passed through
- rd_m  in  RA_W  destination register
- pc_plus4_m, alu_result_m, write_data_m  in  XLEN  PC+4, address/ALU result, store data
- load_type_m  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- store_type_m  in  3  funct3: 000 SB, 001 SH, 010 SW
- stall_m  out  1  hold IF/ID/EX/M upstream registers
- dmem_req, dmem_we  out  1  request / write enable
- dmem_addr  out  XLEN  word address (alu_result_m with bits [1:0] = 0)
- dmem_wdata  out  XLEN  lane-aligned store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  request complete; rdata valid in the same cycle
- dmem_rdata  in  XLEN  raw word read
- valid_w, reg_write_w  out  1
- result_src_w  out  2
- rd_w  out  RA_W
- pc_plus4_w, alu_result_w, read_data_w  out  XLEN  (read_data_w is extended load data)
- misalign_w, fault_w  out  1  exception flags for the instruction in W

Behaviour:
- Reset: every W output = 0, state = IDLE, timeout counter = 0. While rst=1, dmem_req = 0 and stall_m = 0.
- mem_op = valid_m & (mem_read_m | mem_write_m). mem_read_m and mem_write_m are never both 1.
- Misalignment:
  - Halfword access (LH/LHU/SH) with addr[0] = 1 is misaligned.
  - Word access (LW/SW) with addr[1:0] ≠ 0 is misaligned.
- Misaligned access:
  - No request is issued and there is no stall.
  - Next cycle: valid_w = 1, misalign_w = 1, reg_write_w = 0.
- Non-memory valid instruction: MEM/WB loads the inputs; latency 1; read_data_w = 0.
- valid_m = 0: a bubble is loaded (valid_w = 0, reg_write_w = 0, flags = 0).
- State machine, states IDLE and WAIT:
  - IDLE with an aligned mem_op: dmem_req = 1 combinationally.
    - If dmem_ack = 1 in the same cycle (zero-wait), the access completes and MEM/WB loads on that edge; stall_m = 0.
    - Otherwise stall_m = 1 and the state goes to WAIT with counter = 1.
  - WAIT: dmem_req = 1 and stall_m = 1.
    - Request fields stay stable, because upstream is held.
    - On dmem_ack: complete, stall_m = 0 that cycle, return to IDLE.
    - If counter = TIMEOUT and ack = 0: abort and return to IDLE. Next cycle valid_w = 1, fault_w = 1, reg_write_w = 0. An ack arriving later while in IDLE with no request is ignored.
    - Otherwise the counter increments (saturating width clog2(TIMEOUT+1)).
- While stall_m = 1 and the access has not completed, MEM/WB loads a bubble each edge.
- Store alignment (off = addr[1:0]):
  - SB: wdata = {4{wd[7:0]}}, be = 0001 << off.
  - SH: wdata = {2{wd[15:0]}}, be = 0011 << off.
  - SW: wdata = wd, be = 1111.
  - For stores, dmem_we = 1. For loads, dmem_we = 0 and be = 1111.
- Load extension: select byte rdata[8*off +: 8] or halfword rdata[16*off[1] +: 16], then sign- or zero-extend per load_type. The extended value is registered into read_data_w on completion.
- Stores complete with reg_write_w passed through (normally 0).
- rst asserted during WAIT: the next edge goes to IDLE and bubbles W; the outstanding ack is ignored.

Decomposition:
- Package mem_pkg:
  - Load-type and store-type funct3 localparams.
  - State enum (IDLE, WAIT).
  - Byte-enable constants.
- One combinational sub-module, mem_lane_align:
  - Inputs: off, load_type, store_type, wd, rdata.
  - Outputs: wdata, be, load_ext, misalign.
- The top level holds the FSM, the counter and the MEM/WB register.

Test Plan:
- ADD result 0x0000002A to rd = 5, valid_m = 1 → next cycle reg_write_w = 1, rd_w = 5, alu_result_w = 0x2A, stall_m never set.
- LB at addr 0x103, zero-wait ack, rdata 0x80FF_1234 → same-cycle req, be = 1111, next cycle read_data_w = 0xFFFF_FF80; the same access with LBU gives 0x0000_0080.
- SH at addr 0x202, write_data 0x0000_BEEF → dmem_wdata = 0xBEEF_BEEF, be = 1100, we = 1.
- LW at addr 0x300, ack after 3 cycles, rdata 0xDEAD_BEEF → stall_m high for 3 cycles with W bubbles, then read_data_w = 0xDEAD_BEEF.
- LW at addr 0x1002 → no dmem_req, misalign_w = 1, reg_write_w = 0. With ack withheld and TIMEOUT = 15 → fault_w = 1 once stall has lasted 15 cycles, then stall clears.
- rst pulsed on the second WAIT cycle, then ack → all W outputs 0, state IDLE, late ack produces no W activity.
